// File: rtl/npc_predict.sv
// -----------------------------------------------------------------------------
// npc_predict: next-PC generator for the pipelined CPU fetch stage.
//
// Holds the fetch PC register and predicts the next fetch address from a
// direct-mapped branch target buffer (BTB) of 2-bit saturating counters.
// EX feeds back the resolved outcome of each control-flow instruction. A
// mispredict redirects fetch and asks IF/ID and ID/EX to flush.
//
// Optional feature macro: NPC_BTB_EN
//   defined   : BTB storage, lookup and training are built.
//   undefined : no BTB storage; static not-taken prediction (pc_o + 4). Every
//               taken branch or jump then redirects from EX.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   pc_write           1 = PC may advance, 0 = hold (load-use stall)
//   ex_valid           EX holds a valid control-flow instruction
//   ex_is_branch       EX instruction is a conditional branch
//   ex_is_jump         EX instruction is JAL/JALR (wins if both are set)
//   ex_pc              PC of the EX instruction
//   ex_taken           resolved direction
//   ex_target          resolved target
//   ex_pred_taken      prediction carried down the pipe with the instruction
//   ex_pred_target     predicted target carried with the instruction
//   pc_o               current fetch PC
//   pred_taken_o       prediction for pc_o
//   pred_target_o      predicted target for pc_o (pc_o + 4 on a BTB miss)
//   redirect_o         mispredict detected this cycle; flush IF/ID and ID/EX
//   redirect_pc_o      correct PC to fetch on a redirect
// -----------------------------------------------------------------------------
module npc_predict #(
  parameter int              XLEN      = 32,
  parameter int              BTB_IDX_W = 4,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            pc_write,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_cf;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  // Sequential fall-through; wraps modulo 2**XLEN.
  assign pc_plus4 = pc_q + XLEN'(4);

  // Mispredict detection and the corrected fetch address.
  always_comb begin
    ex_cf       = ex_valid & (ex_is_branch | ex_is_jump);
    mispredict  = ex_cf & ((ex_taken != ex_pred_taken) |
                           (ex_taken & (ex_target != ex_pred_target)));
    redirect_pc = ex_taken ? ex_target : (ex_pc + XLEN'(4));
  end

  // Next PC: a redirect beats a stall, since the stalled fetch is on the
  // wrong path and must be discarded.
  always_comb begin
    pc_d = pc_q;
    if (mispredict) begin
      pc_d = redirect_pc;
    end else if (pc_write) begin
      pc_d = pred_taken ? pred_target : pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef NPC_BTB_EN
  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = XLEN - BTB_IDX_W - 2;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];

  logic [BTB_IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_hit;
  logic [BTB_IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0]     wr_tag;
  logic                 wr_hit;

  // Lookup on the fetch PC; reads pre-update contents when EX trains the
  // same entry in this cycle.
  always_comb begin
    rd_idx      = pc_q[BTB_IDX_W+1:2];
    rd_tag      = pc_q[XLEN-1:BTB_IDX_W+2];
    rd_hit      = valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);
    pred_taken  = rd_hit & ctr_q[rd_idx][1];
    pred_target = rd_hit ? tgt_q[rd_idx] : pc_plus4;
  end

  // Training from EX; independent of pc_write. Jumps allocate strongly
  // taken, branches weakly taken.
  always_comb begin
    wr_idx  = ex_pc[BTB_IDX_W+1:2];
    wr_tag  = ex_pc[XLEN-1:BTB_IDX_W+2];
    wr_hit  = valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (ex_cf) begin
      if (wr_hit) begin
        ctr_d[wr_idx] = ex_taken ? sat_inc(ctr_q[wr_idx]) : sat_dec(ctr_q[wr_idx]);
      end else if (ex_taken) begin
        valid_d[wr_idx] = 1'b1;
        ctr_d[wr_idx]   = ex_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag/target storage is qualified by valid_q, so it needs no reset. On a
  // taken hit the tag rewrite is a no-op and only the target changes.
  always_ff @(posedge clk) begin
    if (ex_cf & ex_taken) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= ex_target;
    end
  end
`else
  // Static not-taken: always fall through.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
  end
`endif

  assign pc_o          = pc_q;
  assign pred_taken_o  = pred_taken;
  assign pred_target_o = pred_target;
  assign redirect_o    = mispredict;
  assign redirect_pc_o = redirect_pc;

endmodule

// File: tb/tb_npc_predict.sv
module tb_npc_predict;
  localparam int XLEN = 32;
`ifdef NPC_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            pc_write = 1'b0;
  logic            ex_valid = 1'b0;
  logic            ex_is_branch = 1'b0;
  logic            ex_is_jump = 1'b0;
  logic [XLEN-1:0] ex_pc = '0;
  logic            ex_taken = 1'b0;
  logic [XLEN-1:0] ex_target = '0;
  logic            ex_pred_taken = 1'b0;
  logic [XLEN-1:0] ex_pred_target = '0;
  logic [XLEN-1:0] pc_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] exp_q [$];
  string           name_q [$];

  always #5 clk = ~clk;

  npc_predict #(.XLEN(XLEN), .BTB_IDX_W(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn), .pc_write(pc_write), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .pc_o(pc_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chkp(input string name, input logic tk, input logic [XLEN-1:0] tgt);
    chk({name, "_pred_taken"}, {31'b0, pred_taken_o}, {31'b0, tk});
    chk({name, "_pred_target"}, pred_target_o, tgt);
  endtask

  // One clock: drive at negedge, check combinational redirect, push expected
  // next PC, then pop and compare it after the rising edge.
  task automatic cyc(input string name, input logic pw, input logic exv, input logic br,
                     input logic jp, input logic [XLEN-1:0] expc, input logic tk,
                     input logic [XLEN-1:0] tgt, input logic ptk, input logic [XLEN-1:0] ptgt,
                     input logic exp_rd, input logic [XLEN-1:0] exp_rpc,
                     input logic [XLEN-1:0] exp_npc);
    logic [XLEN-1:0] e;
    string n;
    @(negedge clk);
    pc_write = pw; ex_valid = exv; ex_is_branch = br; ex_is_jump = jp;
    ex_pc = expc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    chk({name, "_redirect"}, {31'b0, redirect_o}, {31'b0, exp_rd});
    chk({name, "_redirect_pc"}, redirect_pc_o, exp_rpc);
    exp_q.push_back(exp_npc);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    chk({n, "_pc"}, pc_o, e);
  endtask

  task automatic seq(input string name, input logic pw, input logic [XLEN-1:0] exp_npc);
    cyc(name, pw, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h4, exp_npc);
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_pc", pc_o, 32'h0);
    chkp("reset", 1'b0, 32'h4);
    chk("reset_redirect", {31'b0, redirect_o}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Sequential fetch and stall
    seq("seq1", 1'b1, 32'h4);
    seq("seq2", 1'b1, 32'h8);
    seq("seq3", 1'b1, 32'hC);
    seq("seq4", 1'b1, 32'h10);
    chkp("at10", 1'b0, 32'h14);
    seq("stall1", 1'b0, 32'h10);
    seq("stall2", 1'b0, 32'h10);
    seq("release", 1'b1, 32'h14);

    // Taken branch at 0x20 mispredicted not-taken
    cyc("br_alloc", 1, 1, 1, 0, 32'h20, 1, 32'h40, 0, 32'h0, 1, 32'h40, 32'h40);
    chkp("at40", 1'b0, 32'h44);
    cyc("jmp_to20", 1, 1, 0, 1, 32'h80, 1, 32'h20, 0, 32'h0, 1, 32'h20, 32'h20);
    chkp("pred20", BTB, BTB ? 32'h40 : 32'h24);
    seq("follow_pred", 1'b1, BTB ? 32'h40 : 32'h24);

    // Same branch resolved not-taken twice while predicted taken
    cyc("nt1", 1, 1, 1, 0, 32'h20, 0, 32'h40, 1, 32'h40, 1, 32'h24, 32'h24);
    cyc("nt2", 1, 1, 1, 0, 32'h20, 0, 32'h40, 1, 32'h40, 1, 32'h24, 32'h24);
    cyc("jmp_to20b", 1, 1, 0, 1, 32'h84, 1, 32'h20, 0, 32'h0, 1, 32'h20, 32'h20);
    chkp("pred20_nt", 1'b0, BTB ? 32'h40 : 32'h24);
    cyc("ex_invalid", 1, 0, 1, 0, 32'h20, 1, 32'h200, 0, 32'h0, 0, 32'h200, 32'h24);

    // Redirect overrides stall
    cyc("rd_over_stall", 0, 1, 1, 0, 32'h30, 1, 32'h100, 0, 32'h0, 1, 32'h100, 32'h100);

    // JALR with correct direction but wrong target
    cyc("jmp50_alloc", 1, 1, 0, 1, 32'h50, 1, 32'h80, 0, 32'h0, 1, 32'h80, 32'h80);
    cyc("jalr_tgt", 1, 1, 0, 1, 32'h50, 1, 32'h90, 1, 32'h80, 1, 32'h90, 32'h90);
    cyc("jmp_to50", 1, 1, 0, 1, 32'h88, 1, 32'h50, 0, 32'h0, 1, 32'h50, 32'h50);
    chkp("pred50", BTB, BTB ? 32'h90 : 32'h54);
    cyc("correct_pred", 1, 1, 0, 1, 32'h50, 1, 32'h90, 1, 32'h90, 0, 32'h90,
        BTB ? 32'h90 : 32'h54);

    // Wrap from 0xFFFF_FFFC to 0
    cyc("wrap_setup", 1, 1, 0, 1, 32'h8C, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'hFFFF_FFFC,
        32'hFFFF_FFFC);
    chkp("atFFFC", 1'b0, 32'h0);
    seq("wrap", 1'b1, 32'h0);
    cyc("nt_correct", 1, 1, 1, 0, 32'h60, 0, 32'h70, 0, 32'h70, 0, 32'h64, 32'h4);

    // Mid-operation asynchronous reset
    @(negedge clk);
    pc_write = 1'b1; ex_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_pc", pc_o, 32'h0);
    chk("midrst_redirect", {31'b0, redirect_o}, 32'h0);
    chk("midrst_pred", {31'b0, pred_taken_o}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    cyc("post_rst_jmp", 1, 1, 0, 1, 32'h8C, 1, 32'h50, 0, 32'h0, 1, 32'h50, 32'h50);
    chkp("pred50_lost", 1'b0, 32'h54);

    // Branch and jump both set: allocates as a jump (strongly taken)
    cyc("br_and_jmp", 1, 1, 1, 1, 32'h50, 1, 32'hA0, 0, 32'h0, 1, 32'hA0, 32'hA0);
    cyc("jmp_to50c", 1, 1, 0, 1, 32'h8C, 1, 32'h50, 0, 32'h0, 1, 32'h50, 32'h50);
    chkp("pred50_bj", BTB, BTB ? 32'hA0 : 32'h54);
    cyc("bj_nt", 1, 1, 1, 0, 32'h50, 0, 32'hA0, 1, 32'hA0, 1, 32'h54, 32'h54);
    cyc("jmp_to50d", 1, 1, 0, 1, 32'h8C, 1, 32'h50, 0, 32'h0, 1, 32'h50, 32'h50);
    chkp("pred50_bj_nt", BTB, BTB ? 32'hA0 : 32'h54);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
